// File: rtl/i2s_transmitter.sv
// I2S transmitter: serialises one signed mono sample per 64-BCLK frame onto both channels.
// Accepts samples through a valid/ready handshake into a one-entry holding register.
module i2s_transmitter #(
   parameter int WIDTH    = 24,
   parameter int BCLK_DIV = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             sample_valid,
   output logic             sample_ready,
   output logic             frame_start,
   output logic             underrun,
   output logic             i2s_bclk,
   output logic             i2s_lrclk,
   output logic             i2s_sdata
);

   localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
   localparam int IW = $clog2(WIDTH);

   logic [DW-1:0]    div_cnt_q, div_cnt_d;
   logic [5:0]       bit_cnt_q, bit_cnt_d;
   logic             bclk_q, bclk_d;
   logic             lrclk_q, lrclk_d;
   logic             sdata_q, sdata_d;
   logic             frame_start_q, frame_start_d;
   logic             underrun_q, underrun_d;
   logic             full_q, full_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [WIDTH-1:0] cur_q, cur_d;

   logic             fall;
   logic             accept;
   logic [4:0]       slot_pos;
   logic [IW-1:0]    bit_idx;

   always_comb begin
      fall          = (div_cnt_q == DW'(BCLK_DIV - 1));
      accept        = sample_valid && !full_q;
      div_cnt_d     = fall ? '0 : div_cnt_q + 1'b1;
      bclk_d        = (div_cnt_d >= DW'(BCLK_DIV / 2));
      bit_cnt_d     = bit_cnt_q;
      lrclk_d       = lrclk_q;
      sdata_d       = sdata_q;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;
      full_d        = full_q;
      hold_d        = hold_q;
      cur_d         = cur_q;
      slot_pos      = '0;
      bit_idx       = '0;

      // Accept and load never collide on full: accept requires empty, load only drains when full.
      if (accept) begin
         hold_d = sample_in;
         full_d = 1'b1;
      end

      if (fall) begin
         bit_cnt_d = bit_cnt_q + 1'b1;
         lrclk_d   = bit_cnt_d[5];
         if (bit_cnt_q == 6'd63) begin
            frame_start_d = 1'b1;
            if (full_q) begin
               cur_d  = hold_q;
               full_d = 1'b0;
            end else begin
               underrun_d = 1'b1;
            end
         end
         // Slot bit p carries sample bit WIDTH-p; p=0 is the I2S one-bit delay.
         slot_pos = bit_cnt_d[4:0];
         bit_idx  = IW'(WIDTH) - IW'(slot_pos);
         if (slot_pos != 5'd0 && {1'b0, slot_pos} <= 6'(WIDTH)) begin
            sdata_d = cur_d[bit_idx];
         end else begin
            sdata_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q     <= '0;
         bit_cnt_q     <= '0;
         bclk_q        <= 1'b0;
         lrclk_q       <= 1'b0;
         sdata_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         full_q        <= 1'b0;
         hold_q        <= '0;
         cur_q         <= '0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         bclk_q        <= bclk_d;
         lrclk_q       <= lrclk_d;
         sdata_q       <= sdata_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
         full_q        <= full_d;
         hold_q        <= hold_d;
         cur_q         <= cur_d;
      end
   end

   assign sample_ready = !full_q;
   assign frame_start  = frame_start_q;
   assign underrun     = underrun_q;
   assign i2s_bclk     = bclk_q;
   assign i2s_lrclk    = lrclk_q;
   assign i2s_sdata    = sdata_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter (WIDTH=24, BCLK_DIV=4): frame-by-frame vector table
// plus a hand-written mid-frame reset sequence.
module tb_i2s_transmitter;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] sample_in;
   logic        sample_valid;
   logic        sample_ready;
   logic        frame_start;
   logic        underrun;
   logic        i2s_bclk;
   logic        i2s_lrclk;
   logic        i2s_sdata;

   int errors = 0;
   int checks = 0;

   i2s_transmitter #(.WIDTH(24), .BCLK_DIV(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .sample_in   (sample_in),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .frame_start (frame_start),
      .underrun    (underrun),
      .i2s_bclk    (i2s_bclk),
      .i2s_lrclk   (i2s_lrclk),
      .i2s_sdata   (i2s_sdata)
   );

   always #5 clk = ~clk;

   // mode: 0 = no write, 1 = single write at cycle 6, 2 = valid held (d1 then d2),
   //       3 = valid raised in the load cycle (cycle 255)
   typedef struct {
      int          mode;
      logic [23:0] d1;
      logic [23:0] d2;
      logic [23:0] exp_tx;
      logic        exp_rdy_mid;
      logic        exp_ur;
      logic        exp_rdy_load;
   } frame_vec_t;

   frame_vec_t vecs [9];

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_word(input string name, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %06h expected %06h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Entered at cycle 0 of a frame (sampled mid-low phase), leaves at cycle 0 of the next.
   task automatic run_frame(input string tag, input int mode, input logic [23:0] d1,
                            input logic [23:0] d2, input logic [23:0] exp_tx,
                            input logic exp_rdy_mid);
      logic [23:0] left;
      logic [23:0] right;
      int pad_ones;
      int lr_err;
      int bclk_err;
      int stray;
      int b;
      int p;
      left = '0; right = '0;
      pad_ones = 0; lr_err = 0; bclk_err = 0; stray = 0;
      for (int c = 0; c < 256; c++) begin
         b = c / 4;
         if (c == 1 && sample_valid) sample_valid = 1'b0;
         if ((c % 4) < 2) begin
            if (i2s_bclk !== 1'b0) bclk_err++;
         end else begin
            if (i2s_bclk !== 1'b1) bclk_err++;
         end
         if (c != 0 && (frame_start !== 1'b0 || underrun !== 1'b0)) stray++;
         if ((c % 4) == 2) begin
            if (i2s_lrclk !== (b >= 32)) lr_err++;
            p = b % 32;
            if (p >= 1 && p <= 24) begin
               if (b < 32) left[24-p] = i2s_sdata;
               else        right[24-p] = i2s_sdata;
            end else if (i2s_sdata !== 1'b0) begin
               pad_ones++;
            end
         end
         if (c == 128) chk_bit({tag, ".ready_mid"}, sample_ready, exp_rdy_mid);
         if ((mode == 1 || mode == 2) && c == 6) begin
            chk_bit({tag, ".ready_before_wr"}, sample_ready, 1'b1);
            sample_valid = 1'b1;
            sample_in    = d1;
         end
         if (mode == 1 && c == 7) begin
            chk_bit({tag, ".ready_after_wr"}, sample_ready, 1'b0);
            sample_valid = 1'b0;
         end
         if (mode == 2 && c == 7) begin
            chk_bit({tag, ".ready_after_wr"}, sample_ready, 1'b0);
            sample_in = d2;
         end
         if (mode == 3 && c == 255) begin
            sample_valid = 1'b1;
            sample_in    = d1;
         end
         step();
      end
      chk_word({tag, ".left"}, left, exp_tx);
      chk_word({tag, ".right"}, right, exp_tx);
      chk_int({tag, ".pad_ones"}, pad_ones, 0);
      chk_int({tag, ".lrclk_err"}, lr_err, 0);
      chk_int({tag, ".bclk_err"}, bclk_err, 0);
      chk_int({tag, ".stray_pulse"}, stray, 0);
   endtask

   initial begin
      vecs[0] = '{1, 24'h800001, 24'h0,      24'h000000, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{0, 24'h0,      24'h0,      24'h800001, 1'b1, 1'b1, 1'b1};
      vecs[2] = '{1, 24'h7FFFFE, 24'h0,      24'h800001, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{1, 24'hA5C3F0, 24'h0,      24'h7FFFFE, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{2, 24'h123456, 24'h654321, 24'hA5C3F0, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{0, 24'h0,      24'h0,      24'h123456, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{3, 24'h0F0F0F, 24'h0,      24'h654321, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{0, 24'h0,      24'h0,      24'h654321, 1'b0, 1'b0, 1'b1};
      vecs[8] = '{0, 24'h0,      24'h0,      24'h0F0F0F, 1'b1, 1'b1, 1'b1};

      rst          = 1'b1;
      sample_valid = 1'b0;
      sample_in    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_bit("rst.bclk", i2s_bclk, 1'b0);
      chk_bit("rst.lrclk", i2s_lrclk, 1'b0);
      chk_bit("rst.sdata", i2s_sdata, 1'b0);
      chk_bit("rst.frame_start", frame_start, 1'b0);
      chk_bit("rst.underrun", underrun, 1'b0);
      chk_bit("rst.ready", sample_ready, 1'b1);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_frame($sformatf("f%0d", i), vecs[i].mode, vecs[i].d1, vecs[i].d2,
                   vecs[i].exp_tx, vecs[i].exp_rdy_mid);
         chk_bit($sformatf("f%0d.load_frame_start", i), frame_start, 1'b1);
         chk_bit($sformatf("f%0d.load_underrun", i), underrun, vecs[i].exp_ur);
         chk_bit($sformatf("f%0d.load_ready", i), sample_ready, vecs[i].exp_rdy_load);
         $display("frame %0d: tx=%06h ur=%b", i, vecs[i].exp_tx, underrun);
      end

      // Mid-right-slot reset with a sample pending in the holding register.
      for (int c = 0; c < 162; c++) begin
         if (c == 6) begin
            sample_valid = 1'b1;
            sample_in    = 24'hBEEF12;
         end
         if (c == 7) sample_valid = 1'b0;
         step();
      end
      chk_bit("mid.lrclk_right", i2s_lrclk, 1'b1);
      chk_bit("mid.ready_pending", sample_ready, 1'b0);
      rst = 1'b1;
      step();
      chk_bit("midrst.lrclk", i2s_lrclk, 1'b0);
      chk_bit("midrst.sdata", i2s_sdata, 1'b0);
      chk_bit("midrst.bclk", i2s_bclk, 1'b0);
      chk_bit("midrst.ready", sample_ready, 1'b1);
      chk_bit("midrst.frame_start", frame_start, 1'b0);
      rst = 1'b0;
      run_frame("post_rst0", 0, 24'h0, 24'h0, 24'h000000, 1'b1);
      chk_bit("post_rst0.load_frame_start", frame_start, 1'b1);
      chk_bit("post_rst0.load_underrun", underrun, 1'b1);
      chk_bit("post_rst0.load_ready", sample_ready, 1'b1);
      run_frame("post_rst1", 0, 24'h0, 24'h0, 24'h000000, 1'b1);
      $display("mid-frame reset sequence: frame_start=%b underrun=%b", frame_start, underrun);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Serialises the mixer's signed mono output sample onto a standard I2S link (BCLK, LRCLK, SDATA) for the external audio DAC.
- It is the consuming end of the mixer sample path: accepts one sample per frame through a valid/ready handshake.
- Sends each sample on both left and right channels.
- Emits a one-cycle frame strobe that upstream logic uses as its sample-rate enable.

Parameters:
WIDTH, 24, sample width in bits; two's complement; legal range 8..31.
BCLK_DIV, 8, clk cycles per BCLK period; must be even and >= 2.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
sample_in  input  WIDTH  signed mono sample from the mixer.
sample_valid  input  1  sample_in is valid this cycle.
sample_ready  output  1  holding register is empty; a sample is accepted when valid && ready.
frame_start  output  1  one-cycle pulse when a new frame loads into the shifter.
underrun  output  1  one-cycle pulse when a frame loads with no new sample pending.
i2s_bclk  output  1  bit clock.
i2s_lrclk  output  1  word select; 0 = left, 1 = right.
i2s_sdata  output  1  serial data, MSB first.

Behaviour:
- Reset values: div_cnt=0, bit_cnt=0, i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, frame_start=0, underrun=0, sample_ready=1.
- Reset also clears the holding register, its full flag and the shift/last-sample registers to 0.
- Reset mid-frame aborts the frame immediately; no partial-frame continuation.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - i2s_bclk is registered: 0 while div_cnt < BCLK_DIV/2, otherwise 1.
  - The "fall event" is the cycle where div_cnt == BCLK_DIV-1.
- Frame counter:
  - bit_cnt is 6 bits (0..63) and increments by 1 on each fall event, wrapping 63->0.
  - Slot position p = bit_cnt[4:0]; channel = bit_cnt[5].
  - Frame = 64 BCLK = 64*BCLK_DIV clk cycles.
- Outputs update on the fall event, so they change in the same cycle BCLK goes low. The DAC samples on BCLK rising.
  - i2s_lrclk = new bit_cnt[5].
  - i2s_sdata = bit (WIDTH-p) of the current sample for p in 1..WIDTH; 0 for p=0 (I2S one-bit delay) and for p > WIDTH.
- Frame load happens on the fall event where bit_cnt wraps 63->0:
  - If the holding register is full: current sample := holding, full := 0, underrun=0.
  - If it is empty: current sample is kept (repeat last), underrun pulses 1 cycle.
  - frame_start pulses 1 cycle on every load, including the load that follows reset.
- Handshake:
  - sample_ready = !full.
  - Accept on valid && ready: holding := sample_in, full := 1, sample_ready=0 from the next cycle.
  - sample_in is ignored while ready=0; upstream holds valid.
- Simultaneous accept and load, with holding empty in that cycle: the load sees empty (underrun pulses, last sample repeats). The accepted sample is stored in holding for the next frame.
- Latency: a sample accepted before load event L goes out in frame L. Its left MSB is on i2s_sdata one BCLK after L, i.e. BCLK_DIV cycles after frame_start. The right MSB follows 32 BCLK later.
- First frame after reset transmits zeros. The first load occurs after 64*BCLK_DIV cycles.
- No arithmetic; sign bits are transmitted unchanged.

Test Plan:
1. Reset, BCLK_DIV=4, WIDTH=24: all outputs 0 and sample_ready=1 during reset. bclk is 0,0,1,1 repeating from the first cycle after reset. lrclk rises after 32*4=128 cycles.
2. Write 0x800001 during frame 0: sample_ready drops the next cycle. At cycle 256 frame_start=1, underrun=0, sample_ready returns to 1. Left slot sdata bits p=1..24 = 1,0x22,1, and p=0 and p=25..31 = 0. The right slot is identical.
3. No write before the second load: at cycle 512 frame_start=1 and underrun=1, and 0x800001 is retransmitted in both slots.
4. sample_valid held high with 0x123456 then 0x654321: only 0x123456 is accepted. 0x654321 is accepted the cycle after the next frame_start and appears one frame later.
5. sample_valid asserted exactly in the load cycle with holding empty: underrun=1, old sample repeats, the new sample appears in the following frame, and sample_ready=0 for that frame.
6. Assert rst at bit_cnt=40 mid-right-slot: the next cycle shows lrclk=0, sdata=0, bclk=0 and sample_ready=1. The pending sample is discarded, and the next frame_start comes 256 cycles after reset release.
